value_ramp_ctrl: RTL and testbench
==================================

# value_ramp_ctrl

Avalon-MM slave that owns a 32-bit drive value, such as a motor or PWM setpoint, and moves it toward a software-written target in bounded steps at a programmed clock interval. It replaces a bare PIO output register wherever the Nios II must not slam the downstream value. Software writes TARGET/STEP/INTERVAL; the block sequences `out_value` autonomously and raises a done interrupt on arrival.

## Interface
- INIT_VALUE, 0: reset value of `out_value` and TARGET (signed 32-bit).
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock, asynchronous, active-low.
- address  in  3  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read mux of `address`; unmapped addresses read 0.
- out_value  out  32  current drive value, signed two's complement, registered.
- busy  out  1  high while state is RUN or PAUSE.
- irq  out  1  DONE & IRQ_EN, registered-source level.

## Operation
- A write occurs when `chipselect & ~write_n`; there is no wait state.
- Register map:
  - 0 TARGET, RW signed.
  - 1 STEP, RW unsigned magnitude.
  - 2 INTERVAL, RW unsigned.
  - 3 CURRENT, RO = `out_value`.
  - 4 CTRL: bit0 ENABLE RW, bit1 IRQ_EN RW, bit2 DONE (write 1 to clear), bit3 BUSY RO, others read 0.
  - 5 FORCE, WO, reads 0.
- FSM states:
  - IDLE:
    - A TARGET write with ENABLE=1 and STEP≠0 and new target ≠ `out_value` → RUN, with the counter loaded with INTERVAL.
    - A TARGET write equal to `out_value`, or with STEP=0 → `out_value` <= target at the next edge, DONE set, stay IDLE.
    - A TARGET write with ENABLE=0 and STEP≠0 → PAUSE.
  - RUN:
    - Counter≠0: decrement.
    - Counter=0: apply one step and reload INTERVAL.
    - If the step lands on the target: → IDLE and set DONE.
    - ENABLE written 0 → PAUSE; the counter freezes.
  - PAUSE: ENABLE written 1 → RUN, resuming the frozen counter.
  - FORCE write (any state): `out_value` <= writedata, TARGET <= writedata, → IDLE. DONE is not set and the counter is cleared.
- Step arithmetic:
  - diff = target − `out_value`, computed sign-extended to 33 bits (no overflow).
  - If |diff| ≤ STEP, `out_value` <= target (clamp, never overshoot).
  - Otherwise `out_value` ± STEP in the sign direction of diff, with the sum formed in 33 bits.
- Retarget during RUN/PAUSE: TARGET is updated and the counter is untouched. If new target = `out_value`, the next step cycle finishes immediately (→ IDLE, DONE set).
- STEP and INTERVAL may be rewritten at any time; the new values take effect at the next step or reload.

## Timing
- Reset (async assert, sync release):
  - `out_value` = TARGET = INIT_VALUE.
  - STEP = INTERVAL = 0.
  - ENABLE = IRQ_EN = DONE = 0.
  - State IDLE; `busy` = 0; `irq` = 0; counter 0.
- Reset mid-ramp aborts immediately to the values above.
- Registers update at the clock edge where the write is sampled; readdata reflects the new value in the following cycle.
- Step spacing: a TARGET write sampled at edge E0 (from IDLE) produces the first `out_value` change at edge E0+INTERVAL+1. Subsequent steps follow every INTERVAL+1 edges; with INTERVAL=0, one step per clock.
- Bus priority: in a cycle carrying any bus write to TARGET, STEP or FORCE, no step is applied and the counter holds, deferring the step by one cycle. Writes to other registers do not inhibit stepping.
- DONE sets at the same edge `out_value` reaches the target; `irq` follows combinationally from the DONE/IRQ_EN flops.
- A DONE set and a W1C write in the same cycle: set wins.
- `busy` deasserts at the same edge as DONE sets.

## Test plan
- Reset then read every register → CURRENT=INIT_VALUE, CTRL=0, `irq`=0, `busy`=0.
- ENABLE=1, STEP=10, INTERVAL=3, TARGET=35 from 0 → `out_value` 10, 20, 30, 35 at E0+4/8/12/16. DONE sets at E0+16; `irq` asserts only if IRQ_EN=1; W1C DONE drops `irq`.
- Negative ramp: `out_value`=5, STEP=4, TARGET=−6 → 1, −3, −6 (clamped). Extreme case: FORCE 0x7FFFFFF0, then TARGET 0x80000000 with STEP 0xFFFFFFFF → a single step lands exactly on 0x80000000 with no wrap.
- STEP=0, TARGET=1234 → `out_value`=1234 at the next edge, DONE=1, `busy` never high.
- Mid-ramp (target 100, STEP 10, INTERVAL 0):
  - ENABLE=0 at `out_value`=30 → holds at 30, `busy`=1.
  - ENABLE=1 → resumes.
  - Retarget to 50 → stops at 50 with DONE.
  - FORCE 7 → `out_value`=7, IDLE, DONE unchanged.
- TARGET write on a step-due cycle (INTERVAL=0) → the step is skipped that cycle and the next step uses the new target. A reset_n pulse mid-ramp → `out_value`=INIT_VALUE immediately.

Source files
------------

// File: rtl/value_ramp_ctrl_if.sv
// Avalon-MM slave bus bundle for value_ramp_ctrl: word address, select, write strobe, data.
interface value_ramp_ctrl_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/value_ramp_ctrl.sv
// Ramps a signed 32-bit drive value toward a software target in bounded steps,
// one step every INTERVAL+1 clocks, with a done flag/interrupt on arrival.
//
// state | meaning
// IDLE  | out_value at rest; waiting for a TARGET write
// RUN   | interval counter running, stepping toward TARGET
// PAUSE | ramp pending/suspended (ENABLE=0); counter frozen
module value_ramp_ctrl #(
   parameter logic signed [31:0] INIT_VALUE = 32'sd0
) (
   input  logic              clk,
   input  logic              reset_n,
   value_ramp_ctrl_if.slave  avs,
   output logic [31:0]       o_out_value,
   output logic              o_busy,
   output logic              o_irq
);

   localparam logic [2:0] ADDR_TARGET   = 3'd0;
   localparam logic [2:0] ADDR_STEP     = 3'd1;
   localparam logic [2:0] ADDR_INTERVAL = 3'd2;
   localparam logic [2:0] ADDR_CURRENT  = 3'd3;
   localparam logic [2:0] ADDR_CTRL     = 3'd4;
   localparam logic [2:0] ADDR_FORCE    = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_out;
   logic [31:0] r_target;
   logic [31:0] r_step;
   logic [31:0] r_interval;
   logic [31:0] r_cnt;
   logic        r_enable;
   logic        r_irq_en;
   logic        r_done;

   state_t      w_state_nxt;
   logic [31:0] w_out_nxt;
   logic [31:0] w_target_nxt;
   logic [31:0] w_cnt_nxt;
   logic        w_done_set;

   logic        w_wr;
   logic        w_wr_target;
   logic        w_wr_step;
   logic        w_wr_interval;
   logic        w_wr_ctrl;
   logic        w_wr_force;
   logic        w_bus_hold;
   logic [31:0] w_wdata;

   logic [32:0] w_diff;
   logic [32:0] w_abs;
   logic        w_clamp;
   logic [31:0] w_step_val;

   assign w_wdata       = avs.writedata;
   assign w_wr          = avs.chipselect & ~avs.write_n;
   assign w_wr_target   = w_wr & (avs.address == ADDR_TARGET);
   assign w_wr_step     = w_wr & (avs.address == ADDR_STEP);
   assign w_wr_interval = w_wr & (avs.address == ADDR_INTERVAL);
   assign w_wr_ctrl     = w_wr & (avs.address == ADDR_CTRL);
   assign w_wr_force    = w_wr & (avs.address == ADDR_FORCE);
   assign w_bus_hold    = w_wr_target | w_wr_step;

   // 33-bit signed difference cannot overflow; |diff| fits in 33 bits unsigned.
   // Past the clamp the result lies between out and target, so 32-bit add/sub is exact.
   assign w_diff     = {r_target[31], r_target} - {r_out[31], r_out};
   assign w_abs      = w_diff[32] ? (33'd0 - w_diff) : w_diff;
   assign w_clamp    = (w_abs <= {1'b0, r_step});
   assign w_step_val = w_clamp    ? r_target :
                       w_diff[32] ? (r_out - r_step) : (r_out + r_step);

   always_comb begin
      w_state_nxt  = r_state;
      w_out_nxt    = r_out;
      w_target_nxt = r_target;
      w_cnt_nxt    = r_cnt;
      w_done_set   = 1'b0;

      if (w_wr_target) begin
         w_target_nxt = w_wdata;
      end

      if (w_wr_force) begin
         w_out_nxt    = w_wdata;
         w_target_nxt = w_wdata;
         w_cnt_nxt    = '0;
         w_state_nxt  = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_wr_target) begin
                  if ((w_wdata == r_out) || (r_step == '0)) begin
                     w_out_nxt  = w_wdata;
                     w_done_set = 1'b1;
                  end else begin
                     w_cnt_nxt   = r_interval;
                     w_state_nxt = r_enable ? ST_RUN : ST_PAUSE;
                  end
               end
            end
            ST_RUN: begin
               if (w_wr_ctrl && !w_wdata[0]) begin
                  w_state_nxt = ST_PAUSE;
               end else if (!w_bus_hold) begin
                  if (r_cnt != '0) begin
                     w_cnt_nxt = r_cnt - 32'd1;
                  end else begin
                     w_out_nxt = w_step_val;
                     w_cnt_nxt = r_interval;
                     if (w_step_val == r_target) begin
                        w_state_nxt = ST_IDLE;
                        w_done_set  = 1'b1;
                     end
                  end
               end
            end
            ST_PAUSE: begin
               if (w_wr_ctrl && w_wdata[0]) begin
                  w_state_nxt = ST_RUN;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_out      <= INIT_VALUE;
         r_target   <= INIT_VALUE;
         r_step     <= '0;
         r_interval <= '0;
         r_cnt      <= '0;
         r_enable   <= 1'b0;
         r_irq_en   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_out    <= w_out_nxt;
         r_target <= w_target_nxt;
         r_cnt    <= w_cnt_nxt;
         if (w_wr_step) begin
            r_step <= w_wdata;
         end
         if (w_wr_interval) begin
            r_interval <= w_wdata;
         end
         if (w_wr_ctrl) begin
            r_enable <= w_wdata[0];
            r_irq_en <= w_wdata[1];
         end
         // A completing step beats a same-cycle write-1-to-clear.
         if (w_done_set) begin
            r_done <= 1'b1;
         end else if (w_wr_ctrl && w_wdata[2]) begin
            r_done <= 1'b0;
         end
      end
   end

   assign o_out_value = r_out;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_irq       = r_done & r_irq_en;

   always_comb begin
      avs.readdata = '0;
      case (avs.address)
         ADDR_TARGET:   avs.readdata = r_target;
         ADDR_STEP:     avs.readdata = r_step;
         ADDR_INTERVAL: avs.readdata = r_interval;
         ADDR_CURRENT:  avs.readdata = r_out;
         ADDR_CTRL:     avs.readdata = {28'd0, o_busy, r_done, r_irq_en, r_enable};
         default:       avs.readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_value_ramp_ctrl.sv
// Directed bench for value_ramp_ctrl: hand-computed ramp values, flags and register reads.
module tb_value_ramp_ctrl;

   localparam logic [31:0] INIT = 32'd5;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] out_value;
   logic        busy;
   logic        irq;
   logic [31:0] rdata;

   int n_checks = 0;
   int n_errors = 0;

   value_ramp_ctrl_if bus ();

   value_ramp_ctrl #(.INIT_VALUE(INIT)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .avs         (bus),
      .o_out_value (out_value),
      .o_busy      (busy),
      .o_irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      #1;
      d = bus.readdata;
      bus.chipselect = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout sim time exceeded");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n        = 1'b0;
      bus.address    = '0;
      bus.writedata  = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // reset state
      rd(3'd0, rdata); chk("rst_target", rdata, INIT);
      rd(3'd1, rdata); chk("rst_step", rdata, 32'd0);
      rd(3'd2, rdata); chk("rst_interval", rdata, 32'd0);
      rd(3'd3, rdata); chk("rst_current", rdata, INIT);
      rd(3'd4, rdata); chk("rst_ctrl", rdata, 32'd0);
      rd(3'd5, rdata); chk("rst_force_rd", rdata, 32'd0);
      rd(3'd7, rdata); chk("rst_unmapped", rdata, 32'd0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_busy", busy, 1'b0);

      // negative ramp from 5 with STEP=4, INTERVAL=0
      wr(3'd4, 32'h1);
      wr(3'd1, 32'd4);
      wr(3'd0, 32'hFFFF_FFFA);
      chk("neg_e0", out_value, 32'd5);
      chk("neg_busy", busy, 1'b1);
      tick(1); chk("neg_1", out_value, 32'd1);
      tick(1); chk("neg_m3", out_value, 32'hFFFF_FFFD);
      tick(1); chk("neg_m6", out_value, 32'hFFFF_FFFA);
      chk("neg_busy_end", busy, 1'b0);
      rd(3'd4, rdata); chk("neg_ctrl_done", rdata, 32'h5);
      wr(3'd4, 32'h5);
      rd(3'd4, rdata); chk("neg_ctrl_clr", rdata, 32'h1);

      // positive ramp: 0 -> 35, STEP=10, INTERVAL=3, IRQ_EN=1
      wr(3'd5, 32'd0);
      chk("frc0", out_value, 32'd0);
      wr(3'd1, 32'd10);
      wr(3'd2, 32'd3);
      wr(3'd4, 32'h3);
      wr(3'd0, 32'd35);
      chk("pos_e0", out_value, 32'd0);
      tick(3); chk("pos_e3", out_value, 32'd0);
      tick(1); chk("pos_e4", out_value, 32'd10);
      tick(4); chk("pos_e8", out_value, 32'd20);
      tick(4); chk("pos_e12", out_value, 32'd30);
      tick(3); chk("pos_e15", out_value, 32'd30);
      chk("pos_irq_e15", irq, 1'b0);
      chk("pos_busy_e15", busy, 1'b1);
      tick(1); chk("pos_e16", out_value, 32'd35);
      chk("pos_busy_e16", busy, 1'b0);
      chk("pos_irq_e16", irq, 1'b1);
      rd(3'd4, rdata); chk("pos_ctrl", rdata, 32'h7);
      wr(3'd4, 32'h7);
      chk("pos_irq_clr", irq, 1'b0);
      rd(3'd4, rdata); chk("pos_ctrl_clr", rdata, 32'h3);

      // extreme: 0x7FFFFFF0 -> 0x80000000 with STEP=0xFFFFFFFF, single clamped step
      wr(3'd2, 32'd0);
      wr(3'd1, 32'hFFFF_FFFF);
      wr(3'd5, 32'h7FFF_FFF0);
      chk("ext_force", out_value, 32'h7FFF_FFF0);
      wr(3'd0, 32'h8000_0000);
      chk("ext_e0", out_value, 32'h7FFF_FFF0);
      tick(1); chk("ext_e1", out_value, 32'h8000_0000);
      chk("ext_busy", busy, 1'b0);
      chk("ext_irq", irq, 1'b1);
      wr(3'd4, 32'h5);
      chk("ext_irq_clr", irq, 1'b0);

      // STEP=0: immediate jump, DONE, never busy
      wr(3'd1, 32'd0);
      wr(3'd0, 32'd1234);
      chk("s0_out", out_value, 32'd1234);
      chk("s0_busy", busy, 1'b0);
      rd(3'd4, rdata); chk("s0_ctrl", rdata, 32'h5);
      chk("s0_busy2", busy, 1'b0);
      wr(3'd4, 32'h5);
      rd(3'd4, rdata); chk("s0_ctrl_clr", rdata, 32'h1);

      // mid-ramp pause / resume / retarget / force
      wr(3'd5, 32'd0);
      wr(3'd1, 32'd10);
      wr(3'd0, 32'd100);
      chk("mid_e0", out_value, 32'd0);
      tick(3); chk("mid_30", out_value, 32'd30);
      wr(3'd4, 32'h0);
      chk("mid_pause", out_value, 32'd30);
      tick(3); chk("mid_hold", out_value, 32'd30);
      chk("mid_busy", busy, 1'b1);
      rd(3'd4, rdata); chk("mid_ctrl_pause", rdata, 32'h8);
      wr(3'd4, 32'h1);
      chk("mid_resume_e0", out_value, 32'd30);
      tick(1); chk("mid_resume", out_value, 32'd40);
      wr(3'd0, 32'd50);
      chk("mid_retgt_hold", out_value, 32'd40);
      tick(1); chk("mid_50", out_value, 32'd50);
      chk("mid_busy_end", busy, 1'b0);
      rd(3'd4, rdata); chk("mid_ctrl_done", rdata, 32'h5);
      wr(3'd5, 32'd7);
      chk("mid_force7", out_value, 32'd7);
      rd(3'd4, rdata); chk("mid_ctrl_force", rdata, 32'h5);
      rd(3'd0, rdata); chk("mid_target_force", rdata, 32'd7);
      wr(3'd4, 32'h5);

      // FORCE during a running ramp aborts it without DONE
      wr(3'd0, 32'd100);
      tick(1); chk("frc_run_17", out_value, 32'd17);
      wr(3'd5, 32'd3);
      chk("frc_run_out", out_value, 32'd3);
      chk("frc_run_busy", busy, 1'b0);
      tick(2); chk("frc_run_hold", out_value, 32'd3);
      rd(3'd4, rdata); chk("frc_run_ctrl", rdata, 32'h1);

      // TARGET write on a step-due cycle skips that step
      wr(3'd0, 32'd50);
      tick(1); chk("skip_13", out_value, 32'd13);
      wr(3'd0, 32'hFFFF_FFEC);
      chk("skip_hold", out_value, 32'd13);
      tick(1); chk("skip_3", out_value, 32'd3);
      tick(3); chk("skip_m20", out_value, 32'hFFFF_FFEC);
      chk("skip_busy", busy, 1'b0);

      // reset mid-ramp
      wr(3'd0, 32'd100);
      tick(2); chk("rr_0", out_value, 32'd0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rr_out", out_value, INIT);
      chk("rr_busy", busy, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      rd(3'd0, rdata); chk("rr_target", rdata, INIT);
      rd(3'd1, rdata); chk("rr_step", rdata, 32'd0);
      rd(3'd4, rdata); chk("rr_ctrl", rdata, 32'd0);
      tick(3); chk("rr_still", out_value, INIT);
      chk("rr_irq", irq, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
